// File: rtl/imem_loader.sv
// Byte-stream program loader: packs bytes big-endian into 32-bit words for the instruction memory.
// Latency: wr_en 1 cycle after the accept of a word's final byte; done 2 cycles after the in_last accept.
// Backpressure: in_ready is high only in LOAD, where every offered byte is taken (1 byte/cycle).
//
// Ports: clk/rst_n (async active-low); start pulse; in_valid/in_ready/in_byte/in_last byte
// stream; wr_en/wr_addr/wr_data imem write port; cpu_hold stall to the core; done/err status;
// words_loaded = words written in the current or last load.
// Build option: define IMEM_LOADER_BOOT_EN to come out of reset already in LOAD (core held).
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    input  logic              in_last,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

`ifdef IMEM_LOADER_BOOT_EN
    localparam state_t RST_STATE  = S_LOAD;
    localparam logic   RST_ACTIVE = 1'b1;
`else
    localparam state_t RST_STATE  = S_IDLE;
    localparam logic   RST_ACTIVE = 1'b0;
`endif

    // Memory is full once 2^ADDR_W words have been written.
    localparam logic [ADDR_W:0] WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_t              state;
    logic [1:0]          byte_cnt;
    logic [23:0]         acc;        // bytes 0..2 of the word being assembled
    logic                accept;
    logic                full;
    logic [DATA_W-1:0]   word_next;  // current word with in_byte inserted, unsent bytes zero

    assign accept = in_valid && in_ready;
    assign full   = (words_loaded == WORDS_MAX);

    always_comb begin
        word_next = '0;
        case (byte_cnt)
            2'd0: word_next = {in_byte, 24'h0};
            2'd1: word_next = {acc[23:16], in_byte, 16'h0};
            2'd2: word_next = {acc[23:8], in_byte, 8'h0};
            default: word_next = {acc, in_byte};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RST_STATE;
            in_ready     <= RST_ACTIVE;
            cpu_hold     <= RST_ACTIVE;
            byte_cnt     <= 2'd0;
            acc          <= 24'h0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state        <= S_LOAD;
                        in_ready     <= 1'b1;
                        cpu_hold     <= 1'b1;
                        byte_cnt     <= 2'd0;
                        done         <= 1'b0;
                        err          <= 1'b0;
                        words_loaded <= '0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (full) begin
                            // Nowhere left to put it: drop the byte and stop.
                            state    <= S_DONE;
                            in_ready <= 1'b0;
                            cpu_hold <= 1'b0;
                            done     <= 1'b1;
                            err      <= 1'b1;
                            byte_cnt <= 2'd0;
                        end else if (in_last || byte_cnt == 2'd3) begin
                            // words_loaded moves with the write register so the
                            // very next byte already sees the updated count.
                            wr_en        <= 1'b1;
                            wr_addr      <= words_loaded[ADDR_W-1:0];
                            wr_data      <= word_next;
                            words_loaded <= words_loaded + 1'b1;
                            byte_cnt     <= 2'd0;
                            if (in_last) begin
                                state    <= S_FLUSH;
                                in_ready <= 1'b0;
                            end
                        end else begin
                            case (byte_cnt)
                                2'd0:    acc <= {in_byte, 16'h0};
                                2'd1:    acc[15:8] <= in_byte;
                                default: acc[7:0] <= in_byte;
                            endcase
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                default: begin
                    // FLUSH: the final word is on the write port this cycle.
                    state    <= S_DONE;
                    cpu_hold <= 1'b0;
                    done     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader for the single-cycle MIPS core; it is the write side of the instruction memory the core fetches from. It accepts a byte stream over a valid/ready handshake and packs it big-endian into 32-bit words. It writes those words to consecutive word addresses starting at 0, matching the core's PC, which steps by 1 per instruction. While loading, it holds the core in stall through `cpu_hold`, and releases the core once the last word is written.

## Interface
Parameters:
- `ADDR_W`, 8: instruction-memory word-address width; matches the 8-bit PC.
- `DATA_W`, 32: instruction width. It must equal 4 bytes.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a load.
- `in_valid`  in  1  `in_byte` is valid.
- `in_byte`  in  8  stream byte.
- `in_last`  in  1  final byte of the program; qualified by `in_valid`.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `wr_en`  out  1  instruction-memory write strobe, one cycle per word.
- `wr_addr`  out  ADDR_W  word address of the write.
- `wr_data`  out  DATA_W  word written.
- `cpu_hold`  out  1  stall request to the PC/core.
- `done`  out  1  load finished; a level signal.
- `err`  out  1  overflow: stream exceeded 2^ADDR_W words.
- `words_loaded`  out  ADDR_W+1  count of words written in the current or last load.

## Operation
- Byte accept: a byte is accepted when `in_valid && in_ready` is true.
- States:
  - IDLE: `in_ready`=0, `cpu_hold`=0.
  - LOAD: `in_ready`=1, `cpu_hold`=1.
  - FLUSH: `in_ready`=0, `cpu_hold`=1.
  - DONE: `in_ready`=0, `cpu_hold`=0, `done`=1.
- IDLE/DONE -> LOAD on `start`. Entering LOAD clears the address, byte counter, `words_loaded`, `done` and `err`.
- `start` is ignored in LOAD and FLUSH.
- Packing: byte 0 goes to [31:24], byte 1 to [23:16], byte 2 to [15:8], byte 3 to [7:0].
- When the 4th byte is accepted without `in_last`: the word is registered into `wr_data`/`wr_addr`, and `wr_en`=1 in the next cycle. After that write, the address and `words_loaded` increment. The state remains LOAD, and byte acceptance continues with no bubble.
- When a byte with `in_last` is accepted: any missing bytes of the current word are zero-filled, the state goes to FLUSH, and the word is written during FLUSH. The next state is DONE.
- Overflow: if a byte is accepted while `words_loaded` = 2^ADDR_W, the byte is discarded, no write occurs, `err` is set to 1, and the state goes to DONE.
- `wr_addr` never wraps.

## Timing
- Write latency: `wr_en` is asserted exactly 1 cycle after the accept cycle of the completing byte.
- `wr_en` is high for 1 cycle per word.
- `wr_addr`/`wr_data` are stable while `wr_en`=1. They hold their last value otherwise.
- `cpu_hold` falls and `done` rises on the edge following the FLUSH cycle, i.e. 2 cycles after the `in_last` accept.
- Throughput: 1 byte per cycle in LOAD.
- Gaps in `in_valid` stall assembly without losing partial bytes.
- Reset (asynchronous, any state, including mid-word):
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0, `done`=0, `err`=0, `words_loaded`=0, byte counter=0.
  - The partial word is discarded.
  - State, `in_ready` and `cpu_hold` follow the Configuration section.

## Configuration
- `IMEM_LOADER_BOOT_EN` defined: reset state is LOAD, with `cpu_hold`=1 and `in_ready`=1 from reset. The core stays stalled until a full program has been loaded, with no `start` needed.
- `IMEM_LOADER_BOOT_EN` undefined: reset state is IDLE, with `cpu_hold`=0 and `in_ready`=0. Loading begins only on `start`.

## Test plan
- Basic load:
  - Stimulus: macro off; pulse `start`; send 20 08 00 05 20 09 00 07, with `in_last` on the 8th byte.
  - Required response: writes addr0=0x20080005, then addr1=0x20090007; `words_loaded`=2; `done`=1 and `cpu_hold`=0 two cycles after the last accept.
- Partial word:
  - Stimulus: send AA BB CC DD 11 22, with `in_last` on 0x22.
  - Required response: addr0=0xAABBCCDD, addr1=0x11220000, `words_loaded`=2.
- Valid gaps:
  - Stimulus: same bytes as the basic load, with `in_valid` deasserted for random 0–3 cycle gaps.
  - Required response: identical writes; exactly one `wr_en` per word.
- Overflow:
  - Stimulus: 1025 bytes with no `in_last`.
  - Required response: 256 writes to addresses 0..255; the 1025th byte causes no write; `err`=1, `done`=1, `words_loaded`=256.
- Reset mid-load:
  - Stimulus: drop `rst_n` after 5 accepted bytes.
  - Required response: outputs are at reset values immediately. With the macro defined, `cpu_hold`=1 and `in_ready`=1; without it, both are 0.
- `start` handling:
  - Stimulus: `start` during LOAD, then `start` in DONE after an `err` load.
  - Required response: `start` during LOAD is ignored. `start` in DONE clears `done`, `err` and `words_loaded`, and the next word is written to addr 0.
